pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/writeback FSM that
// drives PC-control strobes and counts retired instructions.
module pc_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               zero_flag,
  input  logic               resume,
  output logic               pc_en,
  output logic               jump,
  output logic [ADDR_W-1:0]  jump_adr,
  output logic               branch,
  output logic [ADDR_W-1:0]  branch_adr,
  output logic [INSTR_W-1:0] ir,
  output logic               alu_en,
  output logic               reg_we,
  output logic [2:0]         state,
  output logic               halted,
  output logic [15:0]        retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BEQ = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t               r_state;
  state_t               w_next_state;
  logic [INSTR_W-1:0]   r_ir;
  logic [15:0]          r_retired;
  logic [3:0]           w_opcode;
  logic [7:0]           w_target;
  logic                 w_retire;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_opcode = r_ir[15:12];
  assign w_target = r_ir[7:0];

  always_comb begin
    w_next_state = FETCH;
    pc_en        = 1'b0;
    jump         = 1'b0;
    branch       = 1'b0;
    alu_en       = 1'b0;
    reg_we       = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      FETCH:  w_next_state = mem_ready ? DECODE : FETCH;
      DECODE: w_next_state = EXEC;
      EXEC: begin
        case (w_opcode)
          OP_JMP: begin
            jump     = 1'b1;
            w_retire = 1'b1;
          end
          OP_BEQ: begin
            // Taken branch and fall-through increment are mutually exclusive.
            branch   = zero_flag;
            pc_en    = ~zero_flag;
            w_retire = 1'b1;
          end
          OP_HLT: begin
            w_next_state = HALT;
            w_retire     = 1'b1;
          end
          default: begin
            alu_en       = 1'b1;
            w_next_state = WB;
          end
        endcase
      end
      WB: begin
        reg_we   = 1'b1;
        pc_en    = 1'b1;
        w_retire = 1'b1;
      end
      HALT:    w_next_state = resume ? FETCH : HALT;
      default: w_next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= FETCH;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == FETCH && mem_ready) r_ir <= instr;
      if (w_retire) r_retired <= sat_inc(r_retired);
    end
  end

  assign jump_adr   = ADDR_W'(w_target);
  assign branch_adr = ADDR_W'(w_target);
  assign ir         = r_ir;
  assign state      = r_state;
  assign halted     = (r_state == HALT);
  assign retired    = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each step pushes the expected post-edge
// view, which is popped and compared on the following falling edge.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic        zero_flag;
  logic        resume;
  logic        pc_en;
  logic        jump;
  logic [7:0]  jump_adr;
  logic        branch;
  logic [7:0]  branch_adr;
  logic [15:0] ir;
  logic        alu_en;
  logic        reg_we;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] retired;

  pc_sequencer #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .zero_flag  (zero_flag),
    .resume     (resume),
    .pc_en      (pc_en),
    .jump       (jump),
    .jump_adr   (jump_adr),
    .branch     (branch),
    .branch_adr (branch_adr),
    .ir         (ir),
    .alu_en     (alu_en),
    .reg_we     (reg_we),
    .state      (state),
    .halted     (halted),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector order: {pc_en, jump, branch, alu_en, reg_we}
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_PC   = 5'b10000;
  localparam logic [4:0] S_JMP  = 5'b01000;
  localparam logic [4:0] S_BR   = 5'b00100;
  localparam logic [4:0] S_ALU  = 5'b00010;
  localparam logic [4:0] S_WB   = 5'b10001;

  typedef struct {
    logic [2:0]  st;
    logic [4:0]  stb;
    logic [15:0] ret;
    logic [15:0] ir;
  } exp_t;

  exp_t        sb[$];
  int          n_checks;
  int          n_errors;
  logic [15:0] m_ir;
  logic [2:0]  m_st;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst_n, input logic [15:0] ins, input logic mr,
                      input logic zf, input logic res,
                      input logic [2:0] st, input logic [4:0] stb, input logic [15:0] ret);
    exp_t e;
    reset     = rst_n;
    instr     = ins;
    mem_ready = mr;
    zero_flag = zf;
    resume    = res;
    if (!rst_n) m_ir = 16'h0000;
    else if (m_st == 3'd0 && mr) m_ir = ins;
    m_st  = rst_n ? st : 3'd0;
    e.st  = st;
    e.stb = stb;
    e.ret = ret;
    e.ir  = m_ir;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val("state", 32'(state), 32'(e.st));
      check_val("strobes", 32'({pc_en, jump, branch, alu_en, reg_we}), 32'(e.stb));
      check_val("halted", 32'(halted), 32'(e.st == 3'd4));
      check_val("retired", 32'(retired), 32'(e.ret));
      check_val("ir", 32'(ir), 32'(e.ir));
      check_val("jump_adr", 32'(jump_adr), 32'(e.ir[7:0]));
      check_val("branch_adr", 32'(branch_adr), 32'(e.ir[7:0]));
    end
  endtask

  task automatic go(input logic [15:0] ins, input logic mr, input logic zf, input logic res,
                    input logic [2:0] st, input logic [4:0] stb, input logic [15:0] ret);
    step(1'b1, ins, mr, zf, res, st, stb, ret);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_ir      = 16'h0000;
    m_st      = 3'd0;
    reset     = 1'b0;
    instr     = 16'h0000;
    mem_ready = 1'b0;
    zero_flag = 1'b0;
    resume    = 1'b0;
    @(negedge clk);

    // Reset with busy inputs: reset wins over mem_ready and resume
    step(1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 3'd0, S_NONE, 16'd0);
    step(1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0, S_NONE, 16'd0);

    // ALU op: FETCH, DECODE, EXEC(alu_en), WB(reg_we+pc_en)
    go(16'h1234, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, 16'd0);
    go(16'h1234, 1'b1, 1'b0, 1'b0, 3'd2, S_ALU,  16'd0);
    go(16'h1234, 1'b1, 1'b0, 1'b0, 3'd3, S_WB,   16'd0);
    go(16'h1234, 1'b1, 1'b0, 1'b0, 3'd0, S_NONE, 16'd1);

    // JMP
    go(16'hE001, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, 16'd1);
    go(16'hE001, 1'b1, 1'b0, 1'b0, 3'd2, S_JMP,  16'd1);
    go(16'hE001, 1'b1, 1'b0, 1'b0, 3'd0, S_NONE, 16'd2);

    // BEQ taken
    go(16'hD080, 1'b1, 1'b1, 1'b0, 3'd1, S_NONE, 16'd2);
    go(16'hD080, 1'b1, 1'b1, 1'b0, 3'd2, S_BR,   16'd2);
    go(16'hD080, 1'b1, 1'b1, 1'b0, 3'd0, S_NONE, 16'd3);

    // BEQ not taken
    go(16'hD080, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, 16'd3);
    go(16'hD080, 1'b1, 1'b0, 1'b0, 3'd2, S_PC,   16'd3);
    go(16'hD080, 1'b1, 1'b0, 1'b0, 3'd0, S_NONE, 16'd4);

    // Memory stall: FETCH holds, ir keeps previous instruction
    for (int i = 0; i < 5; i++)
      go(16'h5555, 1'b0, 1'b0, 1'b0, 3'd0, S_NONE, 16'd4);
    go(16'h2003, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, 16'd4);
    go(16'h2003, 1'b0, 1'b0, 1'b0, 3'd2, S_ALU,  16'd4);
    go(16'h2003, 1'b0, 1'b0, 1'b0, 3'd3, S_WB,   16'd4);
    go(16'h2003, 1'b0, 1'b0, 1'b0, 3'd0, S_NONE, 16'd5);

    // HLT, stay halted, then resume
    go(16'hF000, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, 16'd5);
    go(16'hF000, 1'b1, 1'b0, 1'b0, 3'd2, S_NONE, 16'd5);
    go(16'hF000, 1'b1, 1'b0, 1'b0, 3'd4, S_NONE, 16'd6);
    for (int i = 0; i < 10; i++)
      go(16'hF000, 1'b1, 1'b0, 1'b0, 3'd4, S_NONE, 16'd6);
    go(16'hF000, 1'b1, 1'b0, 1'b1, 3'd0, S_NONE, 16'd6);

    // resume outside HALT is ignored
    go(16'h3000, 1'b1, 1'b0, 1'b1, 3'd1, S_NONE, 16'd6);
    go(16'h3000, 1'b1, 1'b0, 1'b1, 3'd2, S_ALU,  16'd6);
    go(16'h3000, 1'b1, 1'b0, 1'b0, 3'd3, S_WB,   16'd6);
    go(16'h3000, 1'b1, 1'b0, 1'b0, 3'd0, S_NONE, 16'd7);

    // Reset during EXEC of an ALU op: no writeback
    go(16'h4000, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, 16'd7);
    go(16'h4000, 1'b1, 1'b0, 1'b0, 3'd2, S_ALU,  16'd7);
    step(1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 3'd0, S_NONE, 16'd0);
    go(16'h4000, 1'b0, 1'b0, 1'b0, 3'd0, S_NONE, 16'd0);

    // Reset while halted, with resume and mem_ready also high
    go(16'hF001, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, 16'd0);
    go(16'hF001, 1'b1, 1'b0, 1'b0, 3'd2, S_NONE, 16'd0);
    go(16'hF001, 1'b1, 1'b0, 1'b0, 3'd4, S_NONE, 16'd1);
    step(1'b0, 16'hF001, 1'b1, 1'b0, 1'b1, 3'd0, S_NONE, 16'd0);
    go(16'hF001, 1'b0, 1'b0, 1'b1, 3'd0, S_NONE, 16'd0);

    check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
